// File: rtl/mem_port_arbiter_if.sv
// Shared-memory-port bundle: fetch and load/store request/done handshakes,
// the shared BRAM port itself, and the arbiter busy flag.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wmask;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic [ADDR_W-1:0] a_mem;
    logic [DATA_W-1:0] sd_mem;
    logic [DATA_W-1:0] ld_mem;
    logic [3:0]        mem_write_flag;
    logic              mem_read_flag;
    logic              busy;

    // Requesters and the memory model sit on the master side.
    modport master (
        output i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, ld_mem,
        input  i_rdata, i_done, d_rdata, d_done,
               a_mem, sd_mem, mem_write_flag, mem_read_flag, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, ld_mem,
        output i_rdata, i_done, d_rdata, d_done,
               a_mem, sd_mem, mem_write_flag, mem_read_flag, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter putting the fetcher and load/store unit onto one BRAM port,
// one transaction at a time: strobe, fixed read latency, one-cycle done pulse.
module mem_port_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 2
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

    state_t            state, state_n;
    port_t             last, last_n;
    port_t             gnt, gnt_n;
    logic              is_store, is_store_n;
    logic [2:0]        cnt, cnt_n;
    logic              pick_d;

    logic [ADDR_W-1:0] a_mem_n;
    logic [DATA_W-1:0] sd_mem_n;
    logic [DATA_W-1:0] i_rdata_n;
    logic [DATA_W-1:0] d_rdata_n;
    logic [3:0]        wflag_n;
    logic              rflag_n;
    logic              i_done_n;
    logic              d_done_n;
    logic              busy_n;

    // Every output is computed one cycle early here and registered below,
    // so nothing on the port is combinational from an input.
    always_comb begin
        state_n    = state;
        last_n     = last;
        gnt_n      = gnt;
        is_store_n = is_store;
        cnt_n      = cnt;
        a_mem_n    = bus.a_mem;
        sd_mem_n   = bus.sd_mem;
        i_rdata_n  = bus.i_rdata;
        d_rdata_n  = bus.d_rdata;
        wflag_n    = 4'b0000;
        rflag_n    = 1'b0;
        i_done_n   = 1'b0;
        d_done_n   = 1'b0;

        // On a tie, data wins unless data was the previous grant.
        pick_d = bus.d_req && (!bus.i_req || last == PORT_I);

        case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    gnt_n      = pick_d ? PORT_D : PORT_I;
                    last_n     = gnt_n;
                    is_store_n = pick_d && (bus.d_wmask != 4'b0000);
                    a_mem_n    = pick_d ? bus.d_addr : bus.i_addr;
                    sd_mem_n   = pick_d ? bus.d_wdata : '0;
                    wflag_n    = pick_d ? bus.d_wmask : 4'b0000;
                    rflag_n    = !is_store_n;
                    state_n    = STROBE;
                end
            end
            STROBE: begin
                if (is_store) begin
                    d_done_n = 1'b1;
                    state_n  = DONE;
                end else begin
                    cnt_n   = CNT_INIT;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    if (gnt == PORT_D) begin
                        d_rdata_n = bus.ld_mem;
                        d_done_n  = 1'b1;
                    end else begin
                        i_rdata_n = bus.ld_mem;
                        i_done_n  = 1'b1;
                    end
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            last               <= PORT_I;
            gnt                <= PORT_I;
            is_store           <= 1'b0;
            cnt                <= 3'd0;
            bus.a_mem          <= '0;
            bus.sd_mem         <= '0;
            bus.i_rdata        <= '0;
            bus.d_rdata        <= '0;
            bus.mem_write_flag <= 4'b0000;
            bus.mem_read_flag  <= 1'b0;
            bus.i_done         <= 1'b0;
            bus.d_done         <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            state              <= state_n;
            last               <= last_n;
            gnt                <= gnt_n;
            is_store           <= is_store_n;
            cnt                <= cnt_n;
            bus.a_mem          <= a_mem_n;
            bus.sd_mem         <= sd_mem_n;
            bus.i_rdata        <= i_rdata_n;
            bus.d_rdata        <= d_rdata_n;
            bus.mem_write_flag <= wflag_n;
            bus.mem_read_flag  <= rflag_n;
            bus.i_done         <= i_done_n;
            bus.d_done         <= d_done_n;
            bus.busy           <= busy_n;
        end
    end
endmodule
